dma_ahb_master: RTL and testbench
=================================

// Module: dma_ahb_master
// PURPOSE
//  AHB-Lite single-transfer master downstream of core_set. Executes the rotate read/write
//  command stream (addr/size/write) from core_set on the system bus. Read data is parked in
//  an internal FIFO and drained by the subsequent write commands.
//  O_CMD_READY drives core_set's I_DMA_READY.
// PARAMETERS
//  DATA_W  32  bus data width (HRDATA/HWDATA, FIFO word width)
//  DEPTH   16  FIFO depth in words; power of 2, >=4
//  CNT_W    5  $clog2(DEPTH)+1, FIFO occupancy width
// PORTS
//  I_HCLK        in   1       clock, all logic on rising edge
//  I_HRESET_N    in   1       reset, synchronous, active-low
//  I_CMD_VALID   in   1       command present (core_set O_BUSY & address valid)
//  I_CMD_ADDR    in   32      byte address (core_set O_ADDR)
//  I_CMD_SIZE    in   3       AHB HSIZE code (core_set O_SIZE); 0..2 legal
//  I_CMD_WRITE   in   1       1=write (pops FIFO), 0=read (pushes FIFO)
//  O_CMD_READY   out  1       command accepted when I_CMD_VALID & O_CMD_READY at clock edge
//  O_HADDR       out  32      AHB address
//  O_HTRANS      out  2       2'b00 IDLE / 2'b10 NONSEQ only
//  O_HWRITE      out  1       AHB write
//  O_HSIZE       out  3       AHB size
//  O_HBURST      out  3       constant 3'b000 SINGLE
//  O_HWDATA      out  DATA_W  write data
//  I_HRDATA      in   DATA_W  read data
//  I_HREADY      in   1       transfer/phase completion
//  I_HRESP       in   1       1=ERROR
//  O_BUSY        out  1       address or data phase outstanding
//  O_FIFO_COUNT  out  CNT_W   FIFO occupancy, 0..DEPTH
//  O_ERROR       out  1       sticky bus error
// BEHAVIOUR
//  Reset (I_HRESET_N=0 at edge, any state): O_HTRANS=IDLE, O_HADDR=0, O_HWRITE=0, O_HSIZE=0,
//   O_HWDATA=0, O_BUSY=0, O_ERROR=0, FIFO emptied (count 0); in-flight transfers dropped.
//  Two pipeline registers: A (address phase) and D (data phase); each holds valid/addr/size/wr.
//  Accept at edge N -> A loaded; cycle N+1 O_HTRANS=NONSEQ with registered addr/size/write.
//  A->D at the edge where A valid & I_HREADY=1; a new accept may load A at the same edge.
//  D retires at edge where D valid & I_HREADY=1: read pushes I_HRDATA; write pops FIFO head.
//  O_HWDATA = FIFO head word unmodified (no lane steering) while D holds a write, else hold.
//  rd_if = reads in A/D; wr_if = writes in A/D (0..2 each).
//  O_CMD_READY (combinational) = ~O_ERROR & (~A.valid | I_HREADY) &
//   (I_CMD_WRITE ? (O_FIFO_COUNT - wr_if) > 0 : (O_FIFO_COUNT + rd_if) < DEPTH).
//  Push and pop at the same edge: count unchanged, data order preserved.
//  FIFO never over/underflows by construction; pointers wrap modulo DEPTH.
//  O_BUSY = A.valid | D.valid. Sustained throughput: 1 transfer/cycle with zero-wait slave.
//  Error: I_HRESP=1 & I_HREADY=0 in D -> that cycle O_HTRANS forced IDLE, A cleared,
//   O_ERROR set; D cleared on following I_HREADY. A failed read pushes nothing;
//   a failed write still pops. O_ERROR holds, O_CMD_READY=0 until reset.
//  I_CMD_SIZE>2: accepted, forwarded unchanged (slave responsibility).
// TESTING
//  1 Reset mid-transfer (A and D valid) -> next cycle HTRANS=IDLE, BUSY=0, COUNT=0.
//  2 8 reads 0x100..0x11C, HREADY=1 -> NONSEQ on 8 consecutive cycles, COUNT=8,
//    then 8 writes to 0x200.. -> HWDATA equals read data in order, COUNT=0.
//  3 16 reads, no writes -> 16 accepted; READY=0 with write=0 while COUNT+rd_if=16;
//    READY=1 for write cmd.
//  4 Write with COUNT=0 -> READY=0; no HTRANS issued.
//  5 HREADY low 3 cycles in D -> HADDR/HTRANS of pending A stable; READY=0; resumes in order.
//  6 HRESP ERROR on 3rd read -> IDLE in error cycle, O_ERROR=1, COUNT=2, READY=0 until reset.

Source files
------------

// File: rtl/dma_ahb_master.sv
// AHB-Lite single-transfer master: runs a read/write command stream on the bus, parking
// read data in a FIFO that later write commands drain as HWDATA.
module dma_ahb_master #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET_N,
  input  logic              I_CMD_VALID,
  input  logic [31:0]       I_CMD_ADDR,
  input  logic [2:0]        I_CMD_SIZE,
  input  logic              I_CMD_WRITE,
  output logic              O_CMD_READY,
  output logic [31:0]       O_HADDR,
  output logic [1:0]        O_HTRANS,
  output logic              O_HWRITE,
  output logic [2:0]        O_HSIZE,
  output logic [2:0]        O_HBURST,
  output logic [DATA_W-1:0] O_HWDATA,
  input  logic [DATA_W-1:0] I_HRDATA,
  input  logic              I_HREADY,
  input  logic              I_HRESP,
  output logic              O_BUSY,
  output logic [CNT_W-1:0]  O_FIFO_COUNT,
  output logic              O_ERROR
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              a_valid, a_write;
  logic [31:0]       a_addr;
  logic [2:0]        a_size;
  logic              d_valid, d_write, d_err;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              error_reg;
  logic [DATA_W-1:0] hwdata_hold;

  logic [1:0]        rd_if, wr_if;
  logic [CNT_W:0]    rd_total;
  logic              room_ok, data_ok, err_now, accept, retire, push, pop;

  assign rd_if    = 2'(a_valid & ~a_write) + 2'(d_valid & ~d_write);
  assign wr_if    = 2'(a_valid & a_write) + 2'(d_valid & d_write);
  assign rd_total = {1'b0, count} + (CNT_W+1)'(rd_if);
  assign room_ok  = rd_total < (CNT_W+1)'(DEPTH);
  assign data_ok  = count > CNT_W'(wr_if);

  // First cycle of the two-cycle ERROR response: cancel the queued address phase.
  assign err_now  = d_valid & I_HRESP & ~I_HREADY;

  assign O_CMD_READY = ~error_reg & ~err_now & (~a_valid | I_HREADY) &
                       (I_CMD_WRITE ? data_ok : room_ok);
  assign accept = I_CMD_VALID & O_CMD_READY;
  assign retire = d_valid & I_HREADY;
  assign push   = retire & ~d_write & ~d_err;
  assign pop    = retire & d_write;

  assign O_HADDR      = a_addr;
  assign O_HTRANS     = (a_valid & ~err_now) ? 2'b10 : 2'b00;
  assign O_HWRITE     = a_write;
  assign O_HSIZE      = a_size;
  assign O_HBURST     = 3'b000;
  assign O_HWDATA     = (d_valid & d_write) ? mem[rd_ptr] : hwdata_hold;
  assign O_BUSY       = a_valid | d_valid;
  assign O_FIFO_COUNT = count;
  assign O_ERROR      = error_reg;

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET_N && push) mem[wr_ptr] <= I_HRDATA;
  end

  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      a_valid     <= 1'b0;
      a_write     <= 1'b0;
      a_addr      <= '0;
      a_size      <= '0;
      d_valid     <= 1'b0;
      d_write     <= 1'b0;
      d_err       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      error_reg   <= 1'b0;
      hwdata_hold <= '0;
    end else begin
      if (d_valid & d_write) hwdata_hold <= mem[rd_ptr];
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (err_now) begin
        // D stays until the slave completes the error response; it then retires without a push.
        a_valid   <= 1'b0;
        error_reg <= 1'b1;
        d_err     <= 1'b1;
      end else begin
        if (I_HREADY) begin
          d_valid <= a_valid;
          d_write <= a_write;
          d_err   <= 1'b0;
        end
        if (accept) begin
          a_valid <= 1'b1;
          a_addr  <= I_CMD_ADDR;
          a_size  <= I_CMD_SIZE;
          a_write <= I_CMD_WRITE;
        end else if (I_HREADY) begin
          a_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_ahb_master.sv
// Bench for dma_ahb_master: the bench plays the AHB slave and keeps a transaction-level
// model (pending command queue + data FIFO queue) to predict every bus-visible output.
module tb_dma_ahb_master;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [31:0]       cmd_addr = '0;
  logic [2:0]        cmd_size = '0;
  logic              cmd_write = 1'b0;
  logic              cmd_ready;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize, hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata = '0;
  logic              hready = 1'b1;
  logic              hresp = 1'b0;
  logic              busy, error;
  logic [CNT_W-1:0]  fifo_count;

  always #5 clk = ~clk;

  dma_ahb_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .I_HCLK(clk), .I_HRESET_N(rst_n),
    .I_CMD_VALID(cmd_valid), .I_CMD_ADDR(cmd_addr), .I_CMD_SIZE(cmd_size),
    .I_CMD_WRITE(cmd_write), .O_CMD_READY(cmd_ready),
    .O_HADDR(haddr), .O_HTRANS(htrans), .O_HWRITE(hwrite), .O_HSIZE(hsize),
    .O_HBURST(hburst), .O_HWDATA(hwdata), .I_HRDATA(hrdata), .I_HREADY(hready),
    .I_HRESP(hresp), .O_BUSY(busy), .O_FIFO_COUNT(fifo_count), .O_ERROR(error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
  } cmd_t;

  cmd_t        aq[$];       // accepted commands whose address phase is still pending
  cmd_t        dph;         // command in its data phase
  bit          d_act;
  int          err_phase;   // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
  int          wait_left;
  logic [31:0] rdata_cur;
  logic [31:0] fq[$];       // model of FIFO contents
  bit          m_err;
  int          wait_cfg, fail_read, reads_started;
  bit          wait_rand;
  int          vectors, miscompares;

  function automatic cmd_t mk(input logic [31:0] a, input logic [2:0] s, input logic w);
    cmd_t c;
    c.addr = a; c.size = s; c.wr = w;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input cmd_t c, output bit acc);
    int pend_r, pend_w;
    bit exp_ready, s_ready, s_hready;
    cmd_valid = v; cmd_addr = c.addr; cmd_size = c.size; cmd_write = c.wr;
    hready = 1'b1; hresp = 1'b0;
    if (d_act) begin
      if (err_phase == 1) begin hready = 1'b0; hresp = 1'b1; end
      else if (err_phase == 2) hresp = 1'b1;
      else if (wait_left > 0) hready = 1'b0;
    end
    hrdata = (d_act && !dph.wr) ? rdata_cur : 32'h0;
    #2;
    pend_r = 0; pend_w = 0;
    foreach (aq[i]) if (aq[i].wr) pend_w++; else pend_r++;
    if (d_act) begin if (dph.wr) pend_w++; else pend_r++; end
    exp_ready = !m_err && (err_phase != 1) && (aq.size() == 0 || hready) &&
                (c.wr ? (fq.size() - pend_w) > 0 : (fq.size() + pend_r) < DEPTH);
    chk("ready", 64'(cmd_ready), 64'(exp_ready));
    if (err_phase == 1) chk("htrans_err_cycle", 64'(htrans), 64'(0));
    else begin
      chk("htrans", 64'(htrans), (aq.size() > 0) ? 64'(2) : 64'(0));
      if (aq.size() > 0) begin
        chk("haddr", 64'(haddr), 64'(aq[0].addr));
        chk("hwrite", 64'(hwrite), 64'(aq[0].wr));
        chk("hsize", 64'(hsize), 64'(aq[0].size));
      end
    end
    if (d_act && dph.wr && fq.size() > 0) chk("hwdata", 64'(hwdata), 64'(fq[0]));
    chk("busy", 64'(busy), 64'(aq.size() > 0 || d_act));
    chk("count", 64'(fifo_count), 64'(fq.size()));
    chk("error", 64'(error), 64'(m_err));
    chk("hburst", 64'(hburst), 64'(0));
    s_ready = cmd_ready; s_hready = hready;
    @(posedge clk);
    acc = v && s_ready;
    if (err_phase == 1) begin
      aq.delete(); m_err = 1; err_phase = 2;
    end else begin
      if (d_act && s_hready) begin
        if (dph.wr) void'(fq.pop_front());
        else if (err_phase == 0) fq.push_back(rdata_cur);
        d_act = 0; err_phase = 0;
      end else if (d_act && wait_left > 0) wait_left--;
      if (s_hready && aq.size() > 0) begin
        dph = aq.pop_front(); d_act = 1;
        wait_left = wait_rand ? int'($urandom_range(0, 2)) : wait_cfg;
        rdata_cur = $urandom;
        if (!dph.wr) begin
          reads_started++;
          err_phase = (reads_started == fail_read) ? 1 : 0;
        end
      end
    end
    if (acc) aq.push_back(c);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    aq.delete(); fq.delete(); d_act = 0; err_phase = 0; m_err = 0;
    reads_started = 0; fail_read = -1;
    #1;
    chk("rst_htrans", 64'(htrans), 64'(0));
    chk("rst_haddr", 64'(haddr), 64'(0));
    chk("rst_hwrite", 64'(hwrite), 64'(0));
    chk("rst_hsize", 64'(hsize), 64'(0));
    chk("rst_hwdata", 64'(hwdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic issue(input cmd_t c);
    bit acc;
    acc = 0;
    for (int n = 0; n < 40 && !acc; n++) cycle(1, c, acc);
    chk("issue_accepted", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < 60 && (aq.size() > 0 || d_act); n++) cycle(0, mk(0, 0, 0), acc);
    chk("drained_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    bit acc;
    vectors = 0; miscompares = 0;
    wait_cfg = 0; wait_rand = 0; fail_read = -1;
    do_reset();

    // Reset with both A and D occupied
    wait_cfg = 5;
    cycle(1, mk(32'h40, 2, 0), acc);
    cycle(1, mk(32'h44, 2, 0), acc);
    cycle(0, mk(0, 0, 0), acc);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    do_reset();
    wait_cfg = 0;

    // Write with an empty FIFO is refused
    for (int i = 0; i < 3; i++) begin
      cycle(1, mk(32'h500, 2, 1), acc);
      chk("empty_write_refused", 64'(acc), 64'(0));
    end

    // 8 reads then 8 writes, zero-wait slave
    for (int i = 0; i < 8; i++) issue(mk(32'h100 + 32'(4 * i), 2, 0));
    drain();
    chk("count_after_8_reads", 64'(fifo_count), 64'(8));
    for (int i = 0; i < 8; i++) issue(mk(32'h200 + 32'(4 * i), 2, 1));
    drain();
    chk("count_after_8_writes", 64'(fifo_count), 64'(0));

    // Fill the FIFO completely
    for (int i = 0; i < 16; i++) issue(mk(32'h1000 + 32'(4 * i), 2, 0));
    drain();
    cycle(1, mk(32'h2000, 2, 0), acc);
    chk("full_read_refused", 64'(acc), 64'(0));
    cycle(1, mk(32'h3000, 2, 1), acc);
    chk("full_write_accepted", 64'(acc), 64'(1));
    for (int i = 1; i < 16; i++) issue(mk(32'h3000 + 32'(4 * i), 2, 1));
    drain();

    // Three wait states per data phase
    wait_cfg = 3;
    for (int i = 0; i < 4; i++) issue(mk(32'h600 + 32'(4 * i), 2, 0));
    for (int i = 0; i < 4; i++) issue(mk(32'h700 + 32'(4 * i), 1, 1));
    drain();
    wait_cfg = 0;

    // Randomized mix, random wait states, sizes including illegal codes
    wait_rand = 1;
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), mk({$urandom_range(0, 32'h3FFF), 2'b00},
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))), acc);
    drain();
    wait_rand = 0;

    // ERROR response on the third read
    do_reset();
    fail_read = 3;
    for (int i = 0; i < 4; i++) cycle(1, mk(32'h300 + 32'(4 * i), 2, 0), acc);
    for (int i = 0; i < 4; i++) cycle(0, mk(0, 0, 0), acc);
    chk("err_flag", 64'(error), 64'(1));
    chk("err_count", 64'(fifo_count), 64'(2));
    cycle(1, mk(32'h800, 2, 1), acc);
    chk("err_write_refused", 64'(acc), 64'(0));
    cycle(1, mk(32'h804, 2, 0), acc);
    chk("err_read_refused", 64'(acc), 64'(0));
    do_reset();
    chk("err_cleared_by_reset", 64'(error), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
